load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto a 32-bit word memory.
// Sub-word stores are done as read-modify-write of the containing word.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_READ, WRITE, RESP
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_e      state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] data_q, data_d;
  logic        accept, req_err;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_word, st_word;

  assign accept  = req_valid && req_ready;
  assign req_err = (req_size == 2'b11)
                || (req_size == SZ_H && req_addr[0])
                || (req_size == SZ_W && req_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)              state_d = RESP;
          else if (!req_we)         state_d = LOAD;
          else if (req_size == SZ_W) state_d = WRITE;
          else                      state_d = RMW_READ;
        end
      end
      LOAD:     state_d = RESP;
      RMW_READ: state_d = WRITE;
      WRITE:    state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    ld_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    ld_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    unique case (size_q)
      SZ_B:    ld_word = {{24{!uns_q & ld_b[7]}}, ld_b};
      SZ_H:    ld_word = {{16{!uns_q & ld_h[15]}}, ld_h};
      default: ld_word = mem_rd;
    endcase
    st_word = mem_rd;
    if (size_q == SZ_B)
      st_word[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else if (addr_q[1])
      st_word[31:16] = data_q[15:0];
    else
      st_word[15:0] = data_q[15:0];
  end

  // data_q: store data, then merged word or load result
  always_comb begin
    data_d = data_q;
    unique case (state_q)
      IDLE:     if (accept) data_d = req_wdata;
      LOAD:     data_d = ld_word;
      RMW_READ: data_d = st_word;
      default:  data_d = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      data_q <= data_d;
      if (accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        err_q  <= req_err;
        size_q <= req_size;
        addr_q <= req_addr;
      end
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_we     = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    unique case (state_q)
      IDLE: req_ready = !reset;
      LOAD, RMW_READ: mem_a = {addr_q[31:2], 2'b00};
      WRITE: begin
        mem_we = 1'b1;
        mem_a  = {addr_q[31:2], 2'b00};
        mem_wd = data_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = (we_q || err_q) ? '0 : data_q;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule
